// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM state
// encoding and small decode helpers.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  // Signed variants take operand magnitudes and need a sign fixup at the end.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the datapath (master) and the mul/div unit (slave).
interface md_if #(parameter int WIDTH = 32) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mul_div_unit_cond_negate.sv
// Two's-complement conditional negate: y = neg ? -x : x.
module md_cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  // Negate by invert-plus-one when requested, otherwise pass through.
  always_comb begin
    if (neg) begin
      y = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      y = x;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one result bit per clock
// using a single shared 2*WIDTH accumulator (shift-add multiply, restoring divide).
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH  = MD_WIDTH,
  parameter int DIV_EN = 1
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int CW = (WIDTH == MD_WIDTH) ? CNT_W : $clog2(WIDTH);

  md_state_e            state_r, state_s;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     bmag_r;
  logic [WIDTH-1:0]     araw_r;
  logic                 is_div_r, neg_q_r, neg_r_r, div0_r;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 busy_r, done_r;

  logic                 is_mul_s, is_dv_s, sgn_s, neg_a_s, neg_b_s, b_zero_s;
  logic                 accept_s, rsvd_s;
  logic [WIDTH-1:0]     amag_s, bmag_s;
  logic [WIDTH:0]       sum_s, rem_sh_s, diff_s;
  logic [2*WIDTH-1:0]   mul_next_s, div_next_s, res_s, prod_fix_s;
  logic [WIDTH-1:0]     quot_fix_s, rem_fix_s;

  md_cond_negate #(.WIDTH(WIDTH)) u_neg_a (.x(bus.a), .neg(neg_a_s), .y(amag_s));
  md_cond_negate #(.WIDTH(WIDTH)) u_neg_b (.x(bus.b), .neg(neg_b_s), .y(bmag_s));

  md_cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.x(acc_r), .neg(neg_q_r), .y(prod_fix_s));
  md_cond_negate #(.WIDTH(WIDTH)) u_fix_quot (
    .x(acc_r[WIDTH-1:0]), .neg(neg_q_r), .y(quot_fix_s)
  );
  md_cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .x(acc_r[2*WIDTH-1:WIDTH]), .neg(neg_r_r), .y(rem_fix_s)
  );

  // Opcode decode and request acceptance; reserved ops are accepted without going busy.
  always_comb begin
    is_mul_s = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
    is_dv_s  = (DIV_EN != 0) && ((bus.op == MD_DIV) || (bus.op == MD_DIVU));
    sgn_s    = is_signed_op(bus.op);
    neg_a_s  = sgn_s & bus.a[WIDTH-1];
    neg_b_s  = sgn_s & bus.b[WIDTH-1];
    b_zero_s = (bus.b == {WIDTH{1'b0}});
    accept_s = (state_r == ST_IDLE) && bus.start && (is_mul_s || is_dv_s);
    rsvd_s   = (state_r == ST_IDLE) && bus.start && !(is_mul_s || is_dv_s);
  end

  // One iteration of each algorithm; the extra top bit carries the add-out / borrow.
  always_comb begin
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
               + (acc_r[0] ? {1'b0, bmag_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {sum_s, acc_r[WIDTH-1:1]};
    rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, bmag_r};
    if (!diff_s[WIDTH]) begin
      div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Final HI:LO value; divide-by-zero bypasses the sign fixup and returns the raw dividend.
  always_comb begin
    if (div0_r) begin
      res_s = {araw_r, {WIDTH{1'b1}}};
    end else if (is_div_r) begin
      res_s = {rem_fix_s, quot_fix_s};
    end else begin
      res_s = prod_fix_s;
    end
  end

  // Next-state logic for IDLE -> CALC -> FIXUP -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = ST_FIXUP;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIXUP: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register, iteration counter and registered busy/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_r == ST_FIXUP) || rsvd_s;
      if (accept_s) begin
        cnt_r <= CW'(WIDTH - 1);
      end else if ((state_r == ST_CALC) && (cnt_r != {CW{1'b0}})) begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Operand capture at acceptance and the shared accumulator iterations.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      bmag_r   <= {WIDTH{1'b0}};
      araw_r   <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
    end else if (accept_s) begin
      acc_r    <= {{WIDTH{1'b0}}, amag_s};
      bmag_r   <= bmag_s;
      araw_r   <= bus.a;
      is_div_r <= is_dv_s;
      neg_q_r  <= neg_a_s ^ neg_b_s;
      neg_r_r  <= neg_a_s;
      div0_r   <= is_dv_s & b_zero_s;
    end else if (state_r == ST_CALC) begin
      acc_r <= is_div_r ? div_next_s : mul_next_s;
    end
  end

  // HI/LO: result write in FIXUP, MTHI/MTLO only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_FIXUP) begin
      hi_r <= res_s[2*WIDTH-1:WIDTH];
      lo_r <= res_s[WIDTH-1:0];
    end else if (state_r == ST_IDLE) begin
      if (bus.hi_we) begin
        hi_r <= bus.wdata;
      end
      if (bus.lo_we) begin
        lo_r <= bus.wdata;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
